// File: rtl/pb_pkg.sv
// Shared types and constants for the push-button conditioner: channel FSM
// states, timer width and default timing parameters.
package pb_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int DEF_DB_CNT       = 4;
  localparam int DEF_REPEAT_DELAY = 16;
  localparam int DEF_REPEAT_RATE  = 4;
  localparam int DEF_LONG_CYCLES  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_DONE   = 2'd3
  } pb_state_e;

endpackage

// File: rtl/pb_chan.sv
// One button channel: 2-flop synchronizer, debounce counter, and a hold FSM
// that produces either auto-repeat strobes or a single long-press strobe.
module pb_chan
  import pb_pkg::*;
#(
  parameter int DB_CNT    = DEF_DB_CNT,
  parameter int DELAY     = DEF_REPEAT_DELAY,
  parameter int RATE      = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic level,
  output logic pulse,
  output logic long_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             press_evt, rel_evt;
  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] tmr_inc;
  logic             pulse_q, pulse_d;
  logic             long_q, long_d;

  always_comb begin
    sync1_d = pb_n;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    db_cnt_d  = '0;
    level_d   = level_q;
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    if (~sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = ~level_q;
        press_evt = ~level_q;
        rel_evt   = level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign tmr_inc = (tmr_q == CNT_MAX) ? tmr_q : tmr_q + 1'b1;

  // Hold FSM; a release always wins over a timer expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d = ST_HELD;
          tmr_d   = '0;
          pulse_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (rel_evt) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == DELAY_LAST) begin
          tmr_d = '0;
          if (REPEAT_EN) begin
            state_d = ST_REPEAT;
            pulse_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            long_d  = 1'b1;
          end
        end else begin
          tmr_d = tmr_inc;
        end
      end
      ST_REPEAT: begin
        if (rel_evt) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == RATE_LAST) begin
          tmr_d   = '0;
          pulse_d = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      ST_DONE: begin
        if (rel_evt) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      pulse_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pulse_q  <= pulse_d;
      long_q   <= long_d;
    end
  end

  assign level      = level_q;
  assign pulse      = pulse_q;
  assign long_pulse = long_q;

endmodule

// File: rtl/pb_conditioner.sv
// Conditions the set, digit and hour buttons of a clock-setting panel into
// debounced levels, press/repeat strobes and a long-press strobe on set.
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int DB_CNT       = DEF_DB_CNT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int LONG_CYCLES  = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_s,
  input  logic pb_d,
  input  logic pb_h,
  output logic s_level,
  output logic d_level,
  output logic h_level,
  output logic s_pulse,
  output logic d_pulse,
  output logic h_pulse,
  output logic s_long
);

  logic s_long_w, d_long_w, h_long_w;

  pb_chan #(
    .DB_CNT   (DB_CNT),
    .DELAY    (LONG_CYCLES),
    .RATE     (REPEAT_RATE),
    .REPEAT_EN(1'b0)
  ) u_chan_s (
    .clk       (clk),
    .rst       (rst),
    .pb_n      (pb_s),
    .level     (s_level),
    .pulse     (s_pulse),
    .long_pulse(s_long_w)
  );

  pb_chan #(
    .DB_CNT   (DB_CNT),
    .DELAY    (REPEAT_DELAY),
    .RATE     (REPEAT_RATE),
    .REPEAT_EN(1'b1)
  ) u_chan_d (
    .clk       (clk),
    .rst       (rst),
    .pb_n      (pb_d),
    .level     (d_level),
    .pulse     (d_pulse),
    .long_pulse(d_long_w)
  );

  pb_chan #(
    .DB_CNT   (DB_CNT),
    .DELAY    (REPEAT_DELAY),
    .RATE     (REPEAT_RATE),
    .REPEAT_EN(1'b1)
  ) u_chan_h (
    .clk       (clk),
    .rst       (rst),
    .pb_n      (pb_h),
    .level     (h_level),
    .pulse     (h_pulse),
    .long_pulse(h_long_w)
  );

  // Repeat-mode channels never raise long_pulse, so folding them in is harmless.
  assign s_long = s_long_w | d_long_w | h_long_w;

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner at default timing (DB_CNT=4, delay 16,
// rate 4, long 64): vector table plus hand-built multi-cycle sequences.
module tb_pb_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_s = 1'b1, pb_d = 1'b1, pb_h = 1'b1;
  logic s_level, d_level, h_level, s_pulse, d_pulse, h_pulse, s_long;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       s, d, h;
    logic [6:0] exp;   // {s_level,d_level,h_level,s_pulse,d_pulse,h_pulse,s_long}
    string      name;
  } vec_t;

  vec_t tbl[$];

  pb_conditioner dut (
    .clk    (clk),
    .rst    (rst),
    .pb_s   (pb_s),
    .pb_d   (pb_d),
    .pb_h   (pb_h),
    .s_level(s_level),
    .d_level(d_level),
    .h_level(h_level),
    .s_pulse(s_pulse),
    .d_pulse(d_pulse),
    .h_pulse(h_pulse),
    .s_long (s_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {s_level, d_level, h_level, s_pulse, d_pulse, h_pulse, s_long};
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic h,
                     input logic [6:0] exp, input string nm);
    vec_t v;
    v.s = s; v.d = d; v.h = h; v.exp = exp; v.name = nm;
    tbl.push_back(v);
  endtask

  // Caller has already driven pb_d (and pb_h if both) low before k=0.
  task automatic run_d(input int n, input int rel_at, input bit both);
    logic lvl, pls;
    for (int k = 0; k < n; k++) begin
      if (k == rel_at) begin
        pb_d = 1'b1;
        if (both) pb_h = 1'b1;
      end
      tick();
      lvl = (k >= 5) && (rel_at < 0 || k < rel_at + 5);
      pls = lvl && (k == 5 || (k >= 21 && ((k - 21) % 4) == 0));
      chk($sformatf("d_hold k=%0d", k), {5'b0, d_level, d_pulse}, {5'b0, lvl, pls});
      if (both)
        chk($sformatf("h_hold k=%0d", k), {5'b0, h_level, h_pulse}, {5'b0, lvl, pls});
    end
  endtask

  task automatic idle(input int n);
    pb_s = 1'b1; pb_d = 1'b1; pb_h = 1'b1;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset state
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("reset k=%0d", k), outs(), 7'b0);
    end
    rst = 1'b0;

    add(1, 1, 1, 7'b0000000, "idle0");
    add(1, 1, 1, 7'b0000000, "idle1");
    for (int k = 0; k < 5; k++) add(1, 0, 1, 7'b0000000, $sformatf("d_wait%0d", k));
    add(1, 0, 1, 7'b0100100, "d_press");
    for (int k = 0; k < 4; k++) add(1, 0, 1, 7'b0100000, $sformatf("d_held%0d", k));
    for (int k = 0; k < 5; k++) add(1, 1, 1, 7'b0100000, $sformatf("d_relwait%0d", k));
    add(1, 1, 1, 7'b0000000, "d_released");
    add(1, 1, 1, 7'b0000000, "d_quiet");
    for (int g = 1; g <= 3; g++) begin
      for (int k = 0; k < g; k++) add(1, 1, 0, 7'b0000000, $sformatf("h_glitch%0d_lo%0d", g, k));
      for (int k = 0; k < 6; k++) add(1, 1, 1, 7'b0000000, $sformatf("h_glitch%0d_hi%0d", g, k));
    end

    foreach (tbl[i]) begin
      pb_s = tbl[i].s; pb_d = tbl[i].d; pb_h = tbl[i].h;
      tick();
      chk(tbl[i].name, outs(), tbl[i].exp);
    end
    idle(4);

    // Held d: press, repeats at 21,25,..,41, then release
    pb_d = 1'b0;
    run_d(52, 40, 1'b0);
    idle(4);

    // Release debounced exactly when the first repeat is due
    pb_d = 1'b0;
    run_d(28, 16, 1'b0);
    idle(4);

    // d and h together
    pb_d = 1'b0; pb_h = 1'b0;
    run_d(44, 32, 1'b1);
    idle(4);

    // Reset in the middle of auto-repeat with d still held
    pb_d = 1'b0;
    run_d(24, -1, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst k=%0d", k), outs(), 7'b0);
    end
    rst = 1'b0;
    run_d(30, -1, 1'b0);
    idle(8);

    // Long press on s
    pb_s = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (k == 100) pb_s = 1'b1;
      tick();
      chk($sformatf("s_hold k=%0d", k), outs(),
          {(k >= 5 && k < 105), 2'b00, (k == 5), 2'b00, (k == 69)});
    end
    pb_s = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("s_repress k=%0d", k), outs(),
          {(k >= 5), 2'b00, (k == 5), 3'b000});
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
